// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared states, default sizing and pass-length helper for the mux scan collector
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;
  localparam int DEF_SEL_WIDTH = 2;
  localparam int DEF_N_IN = 2 ** DEF_SEL_WIDTH;
  localparam int DEF_MUX_LATENCY = 2;
  function automatic int pass_cycles(input int n_in, input int mux_latency);
    return n_in + mux_latency;
  endfunction
  localparam int PASS_CYCLES = pass_cycles(DEF_N_IN, DEF_MUX_LATENCY);
endpackage

// File: rtl/mux_scan_capture_tag_pipe.sv
// scan_tag_pipe: delay line carrying {tag_valid, tag_idx} alongside the mux tree latency
module scan_tag_pipe #(
  parameter int W = 2,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_idx,
  output logic         out_valid,
  output logic [W-1:0] out_idx
);
  logic [DEPTH-1:0][W:0] pipe;
  // shift one tag per cycle; the oldest stage names the bit arriving on mux_out now
  always_ff @(posedge clk)
    if (rst) pipe <= '0;
    else pipe <= {pipe[DEPTH-2:0], {in_valid, in_idx}};
  assign {out_valid, out_idx} = pipe[DEPTH-1];
endmodule

// File: rtl/mux_scan_capture.sv
// mux_scan_capture: steps sel through the mux tree and reassembles its output bits into a word (optional parity via MUX_SCAN_PARITY_EN)
module mux_scan_capture
  import mux_scan_pkg::*;
#(
  parameter int SEL_WIDTH = DEF_SEL_WIDTH,
  parameter int N_IN = 2 ** SEL_WIDTH,
  parameter int MUX_LATENCY = DEF_MUX_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [SEL_WIDTH-1:0] sel,
  input  logic                 mux_out,
  output logic                 busy,
  output logic [N_IN-1:0]      data_out,
  output logic                 valid
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                 parity
`endif
);
  localparam int PC = pass_cycles(N_IN, MUX_LATENCY);
  localparam int CW = $clog2(PC);
  state_t state;
  logic [CW-1:0] cnt;
  logic [N_IN-1:0] shadow, shadow_next;
  logic issue, cap_v, done;
  logic [SEL_WIDTH-1:0] issue_idx, cap_idx;
  assign issue = (state == IDLE && start) || state == ISSUE;
  assign issue_idx = state == IDLE ? '0 : sel + 1'b1;
  assign done = state == DRAIN && cnt == CW'(PC - 1);
  scan_tag_pipe #(.W(SEL_WIDTH), .DEPTH(MUX_LATENCY + 1)) u_tags (
    .clk(clk), .rst(rst), .in_valid(issue), .in_idx(issue_idx),
    .out_valid(cap_v), .out_idx(cap_idx)
  );
  // merge the bit whose tag reaches the end of the delay line this cycle
  always_comb begin
    shadow_next = shadow;
    if (cap_v) shadow_next[cap_idx] = mux_out;
  end
  // pass sequencer: issue every sel once, drain the tree, then publish the word
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      cnt <= '0;
      busy <= 1'b0;
      valid <= 1'b0;
      shadow <= '0;
      data_out <= '0;
`ifdef MUX_SCAN_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      shadow <= shadow_next;
      valid <= done;
      if (state == IDLE) begin
        if (start) begin
          state <= ISSUE;
          sel <= '0;
          cnt <= '0;
          busy <= 1'b1;
        end
      end else if (state == ISSUE) begin
        sel <= sel + 1'b1;
        cnt <= cnt + 1'b1;
        if (sel == SEL_WIDTH'(N_IN - 2)) state <= DRAIN;
      end else begin
        cnt <= cnt + 1'b1;
        if (done) begin
          state <= IDLE;
          busy <= 1'b0;
          data_out <= shadow_next;
`ifdef MUX_SCAN_PARITY_EN
          parity <= ^shadow_next;
`endif
        end
      end
    end
endmodule

// File: tb/tb_mux_scan_capture.sv
// tb_mux_scan_capture: loops the collector through a behavioural two-stage 4:1 mux and checks assembled words
module tb_mux_scan_capture;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] sel;
  logic mux_out = 1'b0, m1 = 1'b0;
  logic busy, valid;
  logic [3:0] data_out;
  logic [3:0] a_in = 4'b0000;
`ifdef MUX_SCAN_PARITY_EN
  logic parity;
`endif
  int n_vec = 0, n_bad = 0;

  mux_scan_capture dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .mux_out(mux_out),
    .busy(busy), .data_out(data_out), .valid(valid)
`ifdef MUX_SCAN_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  // Mux4x2 model: two register stages between sel and out
  always @(posedge clk) begin
    m1 <= a_in[sel];
    mux_out <= m1;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one full pass from IDLE: checks sel stepping, valid timing, word and hold
  task automatic run_pass(input logic [3:0] a, input logic [3:0] exp);
    int cyc;
    a_in = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_at_e0", busy, 1);
    chk("sel_at_e0", sel, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("sel_step", sel, k);
      chk("no_early_valid", valid, 0);
    end
    cyc = 3;
    do begin
      tick();
      cyc++;
    end while (!valid && cyc < 20);
    chk("valid_latency", cyc, 6);
    chk("data_out", data_out, exp);
    chk("busy_at_done", busy, 0);
`ifdef MUX_SCAN_PARITY_EN
    chk("parity", parity, ^exp);
`endif
    tick();
    chk("valid_one_cycle", valid, 0);
    chk("data_hold", data_out, exp);
  endtask

  initial begin
    int vcount, first, last, gap_bad;
    vecs[0] = '{4'b1011, 4'b1011};
    vecs[1] = '{4'b0000, 4'b0000};
    vecs[2] = '{4'b1111, 4'b1111};
    vecs[3] = '{4'b0110, 4'b0110};
    vecs[4] = '{4'b1000, 4'b1000};
    vecs[5] = '{4'b0001, 4'b0001};
    vecs[6] = '{4'b0111, 4'b0111};
    vecs[7] = '{4'b0101, 4'b0101};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data_out, 0);

    foreach (vecs[i]) run_pass(vecs[i].a, vecs[i].exp);

    // start while busy is ignored: exactly one valid, at E0+6
    a_in = 4'b0011;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    vcount = 0;
    first = 0;
    for (int c = 3; c <= 14; c++) begin
      tick();
      if (valid) begin
        vcount++;
        if (first == 0) first = c;
      end
    end
    chk("busy_start_one_valid", vcount, 1);
    chk("busy_start_valid_at", first, 6);
    chk("busy_start_data", data_out, 4'b0011);
    chk("busy_start_idle", busy, 0);

    // start held high: a new pass every 7 cycles
    a_in = 4'b0110;
    start = 1'b1;
    tick();
    vcount = 0;
    first = 0;
    last = 0;
    gap_bad = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (valid) begin
        vcount++;
        if (first == 0) first = c;
        else if (c - last != 7) gap_bad++;
        last = c;
        chk("held_data", data_out, 4'b0110);
      end
    end
    start = 1'b0;
    chk("held_count", vcount, 3);
    chk("held_first", first, 6);
    chk("held_gaps", gap_bad, 0);
    tick();
    chk("held_stop_busy", busy, 0);

    // reset mid-pass aborts without a valid pulse
    a_in = 4'b1001;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_sel", sel, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_valid", valid, 0);
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (valid) vcount++;
    end
    chk("midrst_no_valid", vcount, 0);

    // data_out holds after input changes until the next valid
    run_pass(4'b1111, 4'b1111);
    a_in = 4'b0000;
    for (int c = 0; c < 5; c++) tick();
    chk("hold_after_change", data_out, 4'b1111);
    run_pass(4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
